// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register offsets, status bits, FSM states and frame constants
package uart_pkg;

    localparam logic [3:0] TXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] BAUD_OFS   = 4'h8;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_MSB = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX FIFO with push/pop, full/empty and occupancy count
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO, status and baud registers
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h1001_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          BAUD_DIV_RST = 278
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [3:0]    ofs;
    logic          txdata_wr;
    logic          accept;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_ext;
    logic [3:0]    count_sat;
    logic [31:0]   status_word;
    logic [31:0]   rd_data;
    logic          rd_err;
    logic [15:0]   baud_div;
    logic          unused_ok;

    tx_state_e     state, state_nx;
    logic [15:0]   cnt, cnt_nx;
    logic [15:0]   cur_div, cur_div_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          bit_end;

    // The router already steered the request, so only the low nibble is decoded
    assign unused_ok = ^{req_addr[31:4], req_data[31:16], ADDR_BASE};

    assign ofs       = req_addr[3:0];
    assign txdata_wr = req_valid && req_wen && (ofs == TXDATA_OFS);
    assign req_ready = !rst && !(resp_valid && !resp_ready) && !(txdata_wr && fifo_full);
    assign accept    = req_valid && req_ready;
    assign fifo_push = accept && txdata_wr;
    assign tx_busy   = (state != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (req_data[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign count_ext = 32'(fifo_count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        status_word                            = '0;
        status_word[ST_FULL_BIT]               = fifo_full;
        status_word[ST_EMPTY_BIT]              = fifo_empty;
        status_word[ST_BUSY_BIT]               = (state != IDLE);
        status_word[ST_COUNT_MSB:ST_COUNT_LSB] = count_sat;
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ofs)
            TXDATA_OFS: rd_data = '0;
            STATUS_OFS: rd_data = req_wen ? 32'd0 : status_word;
            BAUD_OFS:   rd_data = req_wen ? 32'd0 : {16'd0, baud_div};
            default:    rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            baud_div   <= 16'(BAUD_DIV_RST);
        end else begin
            if (accept) begin
                resp_valid <= 1'b1;
                resp_data  <= rd_data;
                resp_err   <= rd_err;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (accept && req_wen && (ofs == BAUD_OFS)) begin
                baud_div <= (req_data[15:0] == 16'd0) ? 16'd1 : req_data[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_div <= 16'd1;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            cur_div <= cur_div_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    // cur_div is sampled at every bit boundary so a mid-bit divisor change
    // cannot stretch or truncate the bit already in flight
    assign bit_end = (cnt == cur_div - 16'd1);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 16'd1;
        cur_div_nx = cur_div;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        fifo_pop   = 1'b0;
        uart_tx    = STOP_LVL;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_nx   = fifo_rdata;
                    cur_div_nx = baud_div;
                    state_nx   = START;
                end
            end
            START: begin
                uart_tx = START_LVL;
                if (bit_end) begin
                    cnt_nx     = '0;
                    cur_div_nx = baud_div;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                uart_tx = shift[0];
                if (bit_end) begin
                    cnt_nx     = '0;
                    cur_div_nx = baud_div;
                    shift_nx   = {1'b0, shift[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                uart_tx = STOP_LVL;
                if (bit_end) begin
                    cnt_nx     = '0;
                    cur_div_nx = baud_div;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_nx = fifo_rdata;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        uart_tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    logic rec_en = 1'b0;
    logic rec_q[$];

    uart_tx_mmio #(
        .ADDR_BASE    (BASE),
        .FIFO_DEPTH   (8),
        .BAUD_DIV_RST (278)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_en) rec_q.push_back(uart_tx);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [3:0] ofs, input logic wen, input logic [31:0] data,
                       output logic [31:0] rdata, output logic rerr);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = BASE | {28'd0, ofs};
        req_wen   = wen;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_bound", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("resp_valid_after_accept", 32'(resp_valid), 32'd1);
        rdata = resp_data;
        rerr  = resp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [9:0]  fr;
        logic [7:0]  bytes [10];
        logic [7:0]  rx;
        int          n;
        int          stall_idx;
        int          s0;
        int          zeros;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wen    = 1'b0;
        req_data   = '0;
        resp_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        bus(4'h4, 1'b0, 32'd0, rd, er);
        chk("status_reset", rd, 32'h2);
        chk("status_reset_err", 32'(er), 32'd0);
        bus(4'h8, 1'b0, 32'd0, rd, er);
        chk("baud_reset", rd, 32'd278);

        // single 0x55 frame at divisor 4
        bus(4'h8, 1'b1, 32'd4, rd, er);
        chk("baud_write_resp", rd, 32'd0);
        bus(4'h0, 1'b1, 32'h55, rd, er);
        chk("tx55_before_fall", 32'(uart_tx), 32'd1);
        chk("tx55_busy", 32'(tx_busy), 32'd1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("tx55_level", 32'(uart_tx), 32'(fr[i / 4]));
        end
        @(posedge clk);
        #1;
        chk("tx55_done_busy", 32'(tx_busy), 32'd0);
        chk("tx55_done_line", 32'(uart_tx), 32'd1);

        // register map corner cases
        bus(4'hC, 1'b0, 32'd0, rd, er);
        chk("unmapped_err", 32'(er), 32'd1);
        chk("unmapped_data", rd, 32'd0);
        bus(4'h4, 1'b1, 32'hFFFF_FFFF, rd, er);
        chk("status_write_err", 32'(er), 32'd0);
        bus(4'h0, 1'b0, 32'd0, rd, er);
        chk("txdata_read", rd, 32'd0);
        chk("txdata_read_busy", 32'(tx_busy), 32'd0);
        bus(4'h8, 1'b1, 32'd0, rd, er);
        bus(4'h8, 1'b0, 32'd0, rd, er);
        chk("baud_zero_to_one", rd, 32'd1);

        // back-to-back burst at divisor 2
        bus(4'h8, 1'b1, 32'd2, rd, er);
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hF0, 8'h0F, 8'hC3, 8'h81};
        rec_q.delete();
        rec_en = 1'b1;
        stall_idx = -1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_wen   = 1'b1;
            req_addr  = BASE;
            req_data  = {24'd0, bytes[i]};
            n = 0;
            while (!req_ready && n < 100) begin
                if (stall_idx < 0) stall_idx = i;
                @(negedge clk);
                n++;
            end
            chk("b2b_accept_bound", 32'(n < 100), 32'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_first_stall_index", 32'(stall_idx), 32'd9);
        n = 0;
        while (tx_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain_bound", 32'(n < 400), 32'd1);
        repeat (4) @(negedge clk);
        rec_en = 1'b0;
        s0 = -1;
        for (int i = 0; i < rec_q.size(); i++) begin
            if (rec_q[i] == 1'b0) begin
                s0 = i;
                break;
            end
        end
        chk("b2b_capture_len", 32'(s0 >= 0 && rec_q.size() >= s0 + 200), 32'd1);
        if (s0 >= 0 && rec_q.size() >= s0 + 200) begin
            for (int j = 0; j < 10; j++) begin
                for (int b = 0; b < 8; b++) rx[b] = rec_q[s0 + 20 * j + 2 * (b + 1) + 1];
                chk("b2b_frame_data", 32'(rx), 32'(bytes[j]));
                chk("b2b_frame_bounds", {30'd0, rec_q[s0 + 20 * j + 19], rec_q[s0 + 20 * j]}, 32'h2);
            end
        end

        // response back-pressure
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = BASE | 32'h8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("hold_resp_valid", 32'(resp_valid), 32'd1);
        chk("hold_resp_data", resp_data, 32'd2);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = BASE | 32'hC;
        #1;
        chk("hold_resp_valid_later", 32'(resp_valid), 32'd1);
        chk("hold_resp_data_later", resp_data, 32'd2);
        chk("hold_req_ready_later", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("release_new_resp_valid", 32'(resp_valid), 32'd1);
        chk("release_new_resp_err", 32'(resp_err), 32'd1);
        chk("release_new_resp_data", resp_data, 32'd0);

        // reset in the middle of a data bit
        bus(4'h8, 1'b1, 32'd4, rd, er);
        bus(4'h0, 1'b1, 32'hA3, rd, er);
        bus(4'h0, 1'b1, 32'h5A, rd, er);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_uart_tx", 32'(uart_tx), 32'd1);
        chk("abort_tx_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus(4'h4, 1'b0, 32'd0, rd, er);
        chk("abort_status", rd, 32'h2);
        bus(4'h8, 1'b0, 32'd0, rd, er);
        chk("abort_baud_reset", rd, 32'd278);
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) zeros++;
        end
        chk("abort_no_residue", 32'(zeros), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
